// File: rtl/dfc_cmd_feeder.sv
// rtl/dfc_cmd_feeder.sv - host command/data FIFOs replayed onto the DFC command interface
module dfc_cmd_feeder #(
  parameter int LOAD_LEN   = 8,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] host_cmd,
  input  logic       host_cmd_valid,
  output logic       host_cmd_ready,
  input  logic [7:0] host_data,
  input  logic       host_data_valid,
  output logic       host_data_ready,
  input  logic       dfc_busy,
  output logic [1:0] dfc_cmd,
  output logic       dfc_cmd_valid,
  output logic [7:0] dfc_datain,
  output logic [7:0] issue_cnt
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int LCW = $clog2(LOAD_LEN + 1);

  localparam logic [CAW:0]   CMD_FULL  = (CAW+1)'(CMD_DEPTH);
  localparam logic [DAW:0]   DATA_FULL = (DAW+1)'(DATA_DEPTH);
  localparam logic [DAW:0]   LOAD_MIN  = (DAW+1)'(LOAD_LEN);
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_LEN - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]     cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CAW:0]   cmd_cnt;
  logic [7:0]     data_mem [DATA_DEPTH];
  logic [DAW-1:0] data_wr_ptr, data_rd_ptr;
  logic [DAW:0]   data_cnt;

  logic [1:0]     state;
  logic           is_load;
  logic [LCW-1:0] load_idx;

  logic           cmd_push, cmd_pop, data_push, data_pop, start;
  logic [1:0]     cmd_head;
  logic [7:0]     data_head;

  assign host_cmd_ready  = (cmd_cnt != CMD_FULL);
  assign host_data_ready = (data_cnt != DATA_FULL);
  assign cmd_push  = host_cmd_valid & host_cmd_ready;
  assign data_push = host_data_valid & host_data_ready;
  assign cmd_head  = cmd_mem[cmd_rd_ptr];
  assign data_head = data_mem[data_rd_ptr];

  // A load only leaves the FIFO once all its bytes are buffered, so LOAD never starves.
  assign start = (state == IDLE) && (cmd_cnt != '0) && !dfc_busy &&
                 ((cmd_head != 2'd0) || (data_cnt >= LOAD_MIN));

  always_comb begin
    cmd_pop  = start;
    data_pop = 1'b0;
    if (state == ISSUE && is_load)
      data_pop = 1'b1;
    else if (state == LOAD && load_idx != LOAD_LAST)
      data_pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wr_ptr] <= host_cmd;
    if (data_push)
      data_mem[data_wr_ptr] <= host_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_wr_ptr  <= '0;
      cmd_rd_ptr  <= '0;
      cmd_cnt     <= '0;
      data_wr_ptr <= '0;
      data_rd_ptr <= '0;
      data_cnt    <= '0;
    end else begin
      if (cmd_push)
        cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (cmd_pop)
        cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      if (cmd_push && !cmd_pop)
        cmd_cnt <= cmd_cnt + (CAW+1)'(1);
      else if (!cmd_push && cmd_pop)
        cmd_cnt <= cmd_cnt - (CAW+1)'(1);
      if (data_push)
        data_wr_ptr <= data_wr_ptr + DAW'(1);
      if (data_pop)
        data_rd_ptr <= data_rd_ptr + DAW'(1);
      if (data_push && !data_pop)
        data_cnt <= data_cnt + (DAW+1)'(1);
      else if (!data_push && data_pop)
        data_cnt <= data_cnt - (DAW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      is_load       <= 1'b0;
      load_idx      <= '0;
      dfc_cmd       <= 2'd0;
      dfc_cmd_valid <= 1'b0;
      dfc_datain    <= 8'd0;
      issue_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dfc_cmd       <= cmd_head;
            dfc_cmd_valid <= 1'b1;
            issue_cnt     <= issue_cnt + 8'd1;
            is_load       <= (cmd_head == 2'd0);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          dfc_cmd       <= 2'd0;
          dfc_cmd_valid <= 1'b0;
          if (is_load) begin
            dfc_datain <= data_head;
            load_idx   <= '0;
            state      <= LOAD;
          end else begin
            state <= GAP;
          end
        end
        LOAD: begin
          if (load_idx == LOAD_LAST) begin
            dfc_datain <= 8'd0;
            state      <= GAP;
          end else begin
            dfc_datain <= data_head;
            load_idx   <= load_idx + LCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
